// File: rtl/sram_arbiter.sv
// sram_arbiter: fixed-priority video/MCU arbiter driving an async 8-bit SRAM; `define SRAM_ARBITER_BOUNDS_CHECK_EN to skip out-of-range accesses
module sram_arbiter #(
   parameter int WIDTH_X     = 9,
   parameter int WIDTH_Y     = 8,
   parameter int LINE_PIXELS = 320,
   parameter int LINES       = 240
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               videoReadRequest,
   input  logic [WIDTH_X-1:0] videoXCoord,
   input  logic [WIDTH_Y-1:0] videoYCoord,
   output logic [7:0]         videoData,
   output logic               videoDataReady,
   input  logic [WIDTH_X-1:0] memoryXCoord,
   input  logic [WIDTH_Y-1:0] memoryYCoord,
   input  logic               memoryWriteRequest,
   input  logic [7:0]         memoryWriteData,
   output logic               memoryWriteComplete,
   input  logic               memoryReadRequest,
   output logic [7:0]         memoryReadData,
   output logic               memoryReadComplete,
   output logic [16:0]        ramAddress,
   inout  wire  [7:0]         ramData,
   output logic               ramWriteEnable,
   output logic               ramOutputEnable
);
`ifdef SRAM_ARBITER_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_STROBE, WR_HOLD} state_t;
   state_t state_q, state_d;
   logic pend_q, pend_d, wr_armed_q, wr_armed_d, rd_armed_q, rd_armed_d, vid_own_q, vid_own_d;
   logic [WIDTH_X-1:0] pend_x_q, pend_x_d, sel_x;
   logic [WIDTH_Y-1:0] pend_y_q, pend_y_d, sel_y;
   logic [16:0] addr_q, addr_d, sel_addr;
   logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d, vdata_q, vdata_d, mdata_q, mdata_d;
   logic vid_done_q, vid_done_d, rd_done_q, rd_done_d, wr_done_q, wr_done_d;
   logic vready_q, vready_d, rcomp_q, rcomp_d, wcomp_q, wcomp_d;
   logic vid_avail, idle, gnt_v, gnt_w, gnt_r, gnt, oob;
   // Arbitration: a video pulse in the same cycle counts as pending so it beats a simultaneous MCU request
   always_comb begin
      vid_avail = videoReadRequest | pend_q;
      idle      = state_q == IDLE;
      gnt_v     = idle & vid_avail;
      gnt_w     = idle & ~vid_avail & memoryWriteRequest & wr_armed_q;
      gnt_r     = idle & ~vid_avail & ~gnt_w & memoryReadRequest & rd_armed_q;
      gnt       = gnt_v | gnt_w | gnt_r;
      sel_x     = gnt_v ? (videoReadRequest ? videoXCoord : pend_x_q) : memoryXCoord;
      sel_y     = gnt_v ? (videoReadRequest ? videoYCoord : pend_y_q) : memoryYCoord;
      sel_addr  = (17'(sel_y) << 8) + (17'(sel_y) << 6) + 17'(sel_x);
      oob       = BOUNDS_EN && (sel_x >= WIDTH_X'(LINE_PIXELS) || sel_y >= WIDTH_Y'(LINES));
   end
   // Access sequencer; out-of-range grants stay in IDLE and complete via the done flags only
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:      state_d = (gnt_v | gnt_r) & ~oob ? RD_SETUP : gnt_w & ~oob ? WR_SETUP : IDLE;
         RD_SETUP:  state_d = RD_SAMPLE;
         WR_SETUP:  state_d = WR_STROBE;
         WR_STROBE: state_d = WR_HOLD;
         default:   state_d = IDLE;
      endcase
   end
   // Request bookkeeping, access datapath and the registered completion pipeline
   always_comb begin
      pend_d     = gnt_v ? 1'b0 : videoReadRequest ? 1'b1 : pend_q;
      pend_x_d   = videoReadRequest ? videoXCoord : pend_x_q;
      pend_y_d   = videoReadRequest ? videoYCoord : pend_y_q;
      wr_armed_d = ~memoryWriteRequest | (wr_armed_q & ~gnt_w);
      rd_armed_d = ~memoryReadRequest | (rd_armed_q & ~gnt_r);
      vid_own_d  = gnt ? gnt_v : vid_own_q;
      addr_d     = gnt & ~oob ? sel_addr : addr_q;
      wdata_d    = gnt_w ? memoryWriteData : wdata_q;
      rdata_d    = state_q == RD_SAMPLE ? ramData : gnt & oob ? 8'h00 : rdata_q;
      vid_done_d = (state_q == RD_SAMPLE & vid_own_q) | (gnt_v & oob);
      rd_done_d  = (state_q == RD_SAMPLE & ~vid_own_q) | (gnt_r & oob);
      wr_done_d  = (state_q == WR_HOLD) | (gnt_w & oob);
      vready_d   = vid_done_q;
      rcomp_d    = rd_done_q;
      wcomp_d    = wr_done_q;
      vdata_d    = vid_done_q ? rdata_q : vdata_q;
      mdata_d    = rd_done_q ? rdata_q : mdata_q;
   end
   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         pend_x_q   <= '0;
         pend_y_q   <= '0;
         wr_armed_q <= 1'b0;
         rd_armed_q <= 1'b0;
         vid_own_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         vid_done_q <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         vready_q   <= 1'b0;
         rcomp_q    <= 1'b0;
         wcomp_q    <= 1'b0;
         vdata_q    <= '0;
         mdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_x_q   <= pend_x_d;
         pend_y_q   <= pend_y_d;
         wr_armed_q <= wr_armed_d;
         rd_armed_q <= rd_armed_d;
         vid_own_q  <= vid_own_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         vid_done_q <= vid_done_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
         vready_q   <= vready_d;
         rcomp_q    <= rcomp_d;
         wcomp_q    <= wcomp_d;
         vdata_q    <= vdata_d;
         mdata_q    <= mdata_d;
      end
   end
   assign ramData             = (state_q == WR_SETUP || state_q == WR_STROBE || state_q == WR_HOLD) ? wdata_q : 8'bz;
   assign ramWriteEnable      = state_q != WR_STROBE;
   assign ramOutputEnable     = !(state_q == RD_SETUP || state_q == RD_SAMPLE);
   assign ramAddress          = addr_q;
   assign videoData           = vdata_q;
   assign videoDataReady      = vready_q;
   assign memoryReadData      = mdata_q;
   assign memoryReadComplete  = rcomp_q;
   assign memoryWriteComplete = wcomp_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a transaction-level schedule model
module tb_sram_arbiter;
   localparam int MAXC = 8192;
`ifdef SRAM_ARBITER_BOUNDS_CHECK_EN
   localparam bit BEN = 1'b1;
`else
   localparam bit BEN = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b0;
   logic vreq = 1'b0, mwr = 1'b0, mrd = 1'b0;
   logic [8:0] vx = '0, mx = '0;
   logic [7:0] vy = '0, my = '0, mwd = '0;
   logic [7:0] vdata, mrdata;
   logic vready, wcomp, rcomp, ram_we, ram_oe;
   logic [16:0] ram_addr;
   wire [7:0] ram_data;
   logic [7:0] sram [0:131071];
   logic [7:0] exp_mem [0:131071];
   bit e_oe [0:MAXC-1];
   bit e_we [0:MAXC-1];
   bit e_dr [0:MAXC-1];
   bit e_vp [0:MAXC-1];
   bit e_rp [0:MAXC-1];
   bit e_wp [0:MAXC-1];
   logic [16:0] e_addr [0:MAXC-1];
   logic [7:0] e_wd [0:MAXC-1];
   logic [7:0] e_pv [0:MAXC-1];
   int cyc = 0, free_at = 0, npass = 0, ntot = 0;
   bit pend = 0, wa = 0, ra = 0;
   logic [8:0] px = '0;
   logic [7:0] py = '0, hv = '0, hr = '0;

   always #5 clock = ~clock;

   sram_arbiter dut (
      .clock(clock), .reset(reset),
      .videoReadRequest(vreq), .videoXCoord(vx), .videoYCoord(vy),
      .videoData(vdata), .videoDataReady(vready),
      .memoryXCoord(mx), .memoryYCoord(my),
      .memoryWriteRequest(mwr), .memoryWriteData(mwd), .memoryWriteComplete(wcomp),
      .memoryReadRequest(mrd), .memoryReadData(mrdata), .memoryReadComplete(rcomp),
      .ramAddress(ram_addr), .ramData(ram_data),
      .ramWriteEnable(ram_we), .ramOutputEnable(ram_oe)
   );

   assign ram_data = (!ram_oe && ram_we) ? sram[ram_addr] : 8'bz;

   initial forever begin
      @(negedge clock);
      if (!ram_we) sram[ram_addr] = ram_data;
   end

   task automatic chk(input string nm, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Model: an access granted at edge n occupies the SRAM until its completion edge, which is also the next grant opportunity
   task automatic model_step();
      bit va, gv, gw, gr, oob;
      int x, y, n, a;
      cyc++;
      n = cyc;
      if (!reset) begin
         pend = 0; wa = 0; ra = 0; free_at = 0;
         for (int k = n; k < n + 9; k++) begin
            e_oe[k] = 0; e_we[k] = 0; e_dr[k] = 0; e_vp[k] = 0; e_rp[k] = 0; e_wp[k] = 0;
         end
         return;
      end
      va = vreq || pend;
      gv = n >= free_at && va;
      gw = n >= free_at && !gv && mwr && wa;
      gr = n >= free_at && !gv && !gw && mrd && ra;
      if (gv || gw || gr) begin
         x = gv ? int'(vreq ? vx : px) : int'(mx);
         y = gv ? int'(vreq ? vy : py) : int'(my);
         a = (y * 320 + x) % 131072;
         oob = BEN && (x >= 320 || y >= 240);
         if (oob) begin
            free_at = n + 1;
            if (gw) e_wp[n+1] = 1;
            else begin
               if (gv) e_vp[n+1] = 1; else e_rp[n+1] = 1;
               e_pv[n+1] = 8'h00;
            end
         end else if (gw) begin
            for (int k = 0; k < 3; k++) begin
               e_dr[n+k] = 1; e_addr[n+k] = 17'(a); e_wd[n+k] = mwd;
            end
            e_we[n+1] = 1;
            e_wp[n+4] = 1;
            exp_mem[a] = mwd;
            free_at = n + 4;
         end else begin
            for (int k = 0; k < 2; k++) begin
               e_oe[n+k] = 1; e_addr[n+k] = 17'(a);
            end
            if (gv) e_vp[n+3] = 1; else e_rp[n+3] = 1;
            e_pv[n+3] = exp_mem[a];
            free_at = n + 3;
         end
      end
      pend = gv ? 0 : vreq ? 1 : pend;
      if (vreq) begin px = vx; py = vy; end
      wa = !mwr || (wa && !gw);
      ra = !mrd || (ra && !gr);
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   // Per-cycle comparison of every DUT output against the model schedule
   initial forever begin
      @(negedge clock);
      if (!reset) begin
         hv = 0; hr = 0;
         chk("rst_we", ram_we, 1); chk("rst_oe", ram_oe, 1); chk("rst_addr", ram_addr, 0);
         chk("rst_vdata", vdata, 0); chk("rst_mrdata", mrdata, 0);
         chk("rst_vready", vready, 0); chk("rst_rcomp", rcomp, 0); chk("rst_wcomp", wcomp, 0);
      end else begin
         if (e_vp[cyc]) hv = e_pv[cyc];
         if (e_rp[cyc]) hr = e_pv[cyc];
         chk("oe", ram_oe, !e_oe[cyc]);
         chk("we", ram_we, !e_we[cyc]);
         chk("vready", vready, e_vp[cyc]);
         chk("rcomp", rcomp, e_rp[cyc]);
         chk("wcomp", wcomp, e_wp[cyc]);
         chk("vdata", vdata, hv);
         chk("mrdata", mrdata, hr);
         chk("oe_we_excl", int'(ram_oe || ram_we), 1);
         if (e_oe[cyc] || e_dr[cyc]) chk("addr", ram_addr, e_addr[cyc]);
         if (e_dr[cyc]) chk("wdata", ram_data, e_wd[cyc]);
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic dir_write(input int x, input int y, input int d, input bit hold,
                            output int lat, output int wel, output int wad, output int wdt);
      lat = -1; wel = 0; wad = -1; wdt = -1;
      mx = 9'(x); my = 8'(y); mwd = 8'(d); mwr = 1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (!ram_we) begin wel++; wad = ram_addr; wdt = ram_data; end
         if (wcomp) begin lat = i; break; end
      end
      if (hold) @(negedge clock);
      mwr = 0;
      idle_cycles(2);
   endtask

   task automatic dir_read(input int x, input int y, output int lat);
      lat = -1;
      mx = 9'(x); my = 8'(y); mrd = 1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (rcomp) begin lat = i; break; end
      end
      mrd = 0;
      idle_cycles(2);
   endtask

   initial begin
      int lat, wel, wad, wdt, vlat, mst, wt;
      for (int i = 0; i < 131072; i++) begin
         sram[i] = 8'($urandom);
         exp_mem[i] = sram[i];
      end
      sram[76799] = 8'h3C;
      exp_mem[76799] = 8'h3C;
      idle_cycles(3);
      reset = 1;
      idle_cycles(3);
      dir_write(5, 2, 8'hA5, 0, lat, wel, wad, wdt);
      chk("w1_latency", lat, 5); chk("w1_we_cycles", wel, 1);
      chk("w1_addr", wad, 645); chk("w1_data", wdt, 8'hA5); chk("w1_sram", sram[645], 8'hA5);
      dir_read(319, 239, lat);
      chk("r1_latency", lat, 4); chk("r1_data", mrdata, 8'h3C);
      vlat = -1; lat = -1;
      vreq = 1; vx = 9'd10; vy = 8'd1; mx = 9'd7; my = 8'd3; mwd = 8'h5A; mwr = 1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clock);
         vreq = 0;
         if (vready) vlat = i;
         if (wcomp) begin lat = i; break; end
      end
      mwr = 0;
      chk("vw_video_latency", vlat, 4); chk("vw_write_latency", lat, 8);
      chk("vw_vdata", vdata, exp_mem[330]);
      idle_cycles(2);
      dir_write(9, 4, 8'h11, 1, lat, wel, wad, wdt);
      chk("hold_latency", lat, 5);
      wel = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (!ram_we) wel++;
      end
      chk("hold_no_rewrite", wel, 0);
      dir_write(9, 4, 8'h22, 0, lat, wel, wad, wdt);
      chk("rearm_latency", lat, 5); chk("rearm_data", wdt, 8'h22);
      dir_write(320, 0, 8'h77, 0, lat, wel, wad, wdt);
      if (BEN) begin
         chk("oob_latency", lat, 2); chk("oob_we_cycles", wel, 0);
      end else begin
         chk("oob_latency", lat, 5); chk("oob_addr", wad, 320); chk("oob_sram", sram[320], 8'h77);
      end
      mx = 9'd1; my = 8'd1; mwd = 8'h99; mwr = 1;
      idle_cycles(2);
      chk("strobe_we", ram_we, 0);
      #2 reset = 0;
      #1 chk("rst_mid_we", ram_we, 1); chk("rst_mid_oe", ram_oe, 1); chk("rst_mid_addr", ram_addr, 0);
      wel = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if (wcomp) wel++;
      end
      mwr = 0;
      reset = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (wcomp) wel++;
      end
      chk("rst_mid_no_complete", wel, 0);
      mst = 0; wt = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         vreq = $urandom_range(0, 7) == 0;
         if (vreq) begin
            vx = 9'($urandom_range(0, 15) == 0 ? $urandom_range(0, 511) : $urandom_range(0, 319));
            vy = 8'($urandom_range(0, 15) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 239));
         end
         if (mst == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               mwr = $urandom_range(0, 1) == 1;
               mrd = !mwr;
               mx = 9'($urandom_range(0, 15) == 0 ? $urandom_range(0, 511) : $urandom_range(0, 319));
               my = 8'($urandom_range(0, 15) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 239));
               mwd = 8'($urandom);
               mst = 1; wt = 0;
            end
         end else if (mst == 1) begin
            wt++;
            if ((mwr && wcomp) || (mrd && rcomp)) begin
               if ($urandom_range(0, 3) == 0) mst = 2;
               else begin mwr = 0; mrd = 0; mst = 0; end
            end else if (wt > 40) begin
               chk("mcu_timeout", wt, 40);
               mwr = 0; mrd = 0; mst = 0;
            end
         end else begin
            mwr = 0; mrd = 0; mst = 0;
         end
      end
      vreq = 0; mwr = 0; mrd = 0;
      idle_cycles(10);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
